// File: rtl/bird_rom_arbiter_if.sv
// Shared sprite ROM bus: two requester ports, their return paths, and the ROM read port.
// slave = arbiter view; master = requesters plus ROM (driven by the environment).
interface bird_rom_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 6
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;

  modport slave (
    input  req0, req1, addr0, addr1, rom_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_addr
  );

  modport master (
    output req0, req1, addr0, addr1, rom_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_addr
  );
endinterface

// File: rtl/bird_rom_arbiter.sv
// Two-way burst arbiter for one sprite ROM read port; returns tagged words per requester.
// Latency: grant 1 clk after request, data ROM_LAT+1 clks after a beat; no backpressure on returns.
// BIRD_ARB_RR_EN selects round-robin ties; default is fixed priority to requester 0.
module bird_rom_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 6,
  parameter int ROM_LAT = 1,
  parameter int BURST   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  bird_rom_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       cur_req;
  logic       oth_req;
  logic       cur_id;
  logic       beat;
  logic       burst_end;

  logic              tag_vld [ROM_LAT];
  logic              tag_id  [ROM_LAT];
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

`ifdef BIRD_ARB_RR_EN
  logic rr_ptr;
  logic rr_ptr_nxt;
`endif

  always_comb begin
    cur_req = 1'b0;
    oth_req = 1'b0;
    cur_id  = 1'b0;
    case (state)
      G0: begin
        cur_req = bus.req0;
        oth_req = bus.req1;
        cur_id  = 1'b0;
      end
      G1: begin
        cur_req = bus.req1;
        oth_req = bus.req0;
        cur_id  = 1'b1;
      end
      default: ;
    endcase
  end

  // In IDLE cur_req is 0, so a beat is simply "granted requester is asking".
  assign beat      = cur_req;
  assign burst_end = (state != IDLE) && (!cur_req || (cnt == BURST_LAST));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef BIRD_ARB_RR_EN
    rr_ptr_nxt = rr_ptr;
`endif
    if (state == IDLE) begin
      cnt_nxt = 8'd0;
      if (bus.req0 && bus.req1) begin
`ifdef BIRD_ARB_RR_EN
        state_nxt = rr_ptr ? G1 : G0;
`else
        state_nxt = G0;
`endif
      end else if (bus.req0) begin
        state_nxt = G0;
      end else if (bus.req1) begin
        state_nxt = G1;
      end
    end else if (burst_end) begin
      cnt_nxt = 8'd0;
      // The other side always gets the next burst if it is waiting.
      if (oth_req) begin
        state_nxt = cur_id ? G0 : G1;
      end else if (cur_req) begin
        state_nxt = state;
      end else begin
        state_nxt = IDLE;
      end
`ifdef BIRD_ARB_RR_EN
      if (beat || (cnt != 8'd0)) begin
        rr_ptr_nxt = ~cur_id;
      end
`endif
    end else if (beat) begin
      cnt_nxt = cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
`ifdef BIRD_ARB_RR_EN
      rr_ptr <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
`ifdef BIRD_ARB_RR_EN
      rr_ptr <= rr_ptr_nxt;
`endif
    end
  end

  // Tag pipe tracks the ROM's own latency so each word finds its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_id[i]  <= 1'b0;
      end
    end else begin
      tag_vld[0] <= beat;
      tag_id[0]  <= cur_id;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= tag_vld[ROM_LAT-1] && !tag_id[ROM_LAT-1];
      rvalid1 <= tag_vld[ROM_LAT-1] &&  tag_id[ROM_LAT-1];
      if (tag_vld[ROM_LAT-1] && !tag_id[ROM_LAT-1]) begin
        rdata0 <= bus.rom_dout;
      end
      if (tag_vld[ROM_LAT-1] && tag_id[ROM_LAT-1]) begin
        rdata1 <= bus.rom_dout;
      end
    end
  end

  assign bus.gnt0     = (state == G0);
  assign bus.gnt1     = (state == G1);
  assign bus.rom_addr = beat ? (cur_id ? bus.addr1 : bus.addr0) : '0;
  assign bus.rvalid0  = rvalid0;
  assign bus.rvalid1  = rvalid1;
  assign bus.rdata0   = rdata0;
  assign bus.rdata1   = rdata1;
endmodule

// File: tb/tb_bird_rom_arbiter.sv
// Two arbiters (ROM_LAT 1 and 3) share stimulus; a burst/owner model with a response
// schedule predicts grants, ROM address and tagged returns every clock.
module tb_bird_rom_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 6;
  localparam int BURST  = 32;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bird_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_a ();
  bird_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_b ();

  bird_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(LAT_A), .BURST(BURST))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  bird_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(LAT_B), .BURST(BURST))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  // Sprite ROMs: word = address & 63, delivered LAT clocks after the address.
  logic [DATA_W-1:0] rom_a [LAT_A];
  logic [DATA_W-1:0] rom_b [LAT_B];
  always @(posedge clk) begin
    rom_a[0] <= if_a.rom_addr[DATA_W-1:0];
    rom_b[0] <= if_b.rom_addr[DATA_W-1:0];
    for (int i = 1; i < LAT_B; i++) rom_b[i] <= rom_b[i-1];
  end
  assign if_a.rom_dout = rom_a[LAT_A-1];
  assign if_b.rom_dout = rom_b[LAT_B-1];

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  string phase = "init";

  // Reference model: owner 0=none, 1=requester 0, 2=requester 1.
  int owner, used, ptr;
  int sch_vld [2][8];
  int sch_id  [2][8];
  int sch_dat [2][8];
  int exp_rv  [2][2];
  int exp_rd  [2][2];
  logic q0, q1, rr;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s.%s cycle %0d: got %0d expected %0d", phase, name, cyc, obs, expv);
    end
  endtask

  task automatic model_reset();
    owner = 0;
    used  = 0;
    ptr   = 0;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 8; s++) sch_vld[d][s] = 0;
      for (int i = 0; i < 2; i++) begin
        exp_rv[d][i] = 0;
        exp_rd[d][i] = 0;
      end
    end
  endtask

  task automatic model_next(input logic r0, input logic r1, input logic beat);
    logic cur, oth;
    if (owner == 0) begin
      used = 0;
      if (r0 && r1) begin
`ifdef BIRD_ARB_RR_EN
        owner = (ptr == 1) ? 2 : 1;
`else
        owner = 1;
`endif
      end else if (r0) owner = 1;
      else if (r1) owner = 2;
    end else begin
      cur = (owner == 1) ? r0 : r1;
      oth = (owner == 1) ? r1 : r0;
      if (beat) used++;
      if (!cur || used == BURST) begin
`ifdef BIRD_ARB_RR_EN
        if (used > 0) ptr = (owner == 1) ? 1 : 0;
`endif
        owner = oth ? (3 - owner) : (cur ? owner : 0);
        used  = 0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic r0, input logic r1, input int a0, input int a1);
    int   slot, baddr, s, lat;
    logic beat;
    @(negedge clk);
    rst_n = r;
    if_a.req0 = r0;  if_a.req1 = r1;  if_a.addr0 = ADDR_W'(a0);  if_a.addr1 = ADDR_W'(a1);
    if_b.req0 = r0;  if_b.req1 = r1;  if_b.addr0 = ADDR_W'(a0);  if_b.addr1 = ADDR_W'(a1);
    #1;
    slot = cyc % 8;
    if (!r) model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_rv[d][0] = 0;
      exp_rv[d][1] = 0;
      if (r && sch_vld[d][slot] != 0) begin
        exp_rv[d][sch_id[d][slot]] = 1;
        exp_rd[d][sch_id[d][slot]] = sch_dat[d][slot];
        sch_vld[d][slot] = 0;
      end
    end
    beat  = r && ((owner == 1 && r0) || (owner == 2 && r1));
    baddr = beat ? ((owner == 1) ? a0 : a1) : 0;

    chk("a.gnt0", 32'(if_a.gnt0), 32'(owner == 1));
    chk("a.gnt1", 32'(if_a.gnt1), 32'(owner == 2));
    chk("a.rom_addr", 32'(if_a.rom_addr), 32'(baddr));
    chk("a.rvalid0", 32'(if_a.rvalid0), 32'(exp_rv[0][0]));
    chk("a.rvalid1", 32'(if_a.rvalid1), 32'(exp_rv[0][1]));
    chk("a.rdata0", 32'(if_a.rdata0), 32'(exp_rd[0][0]));
    chk("a.rdata1", 32'(if_a.rdata1), 32'(exp_rd[0][1]));
    chk("b.gnt0", 32'(if_b.gnt0), 32'(owner == 1));
    chk("b.gnt1", 32'(if_b.gnt1), 32'(owner == 2));
    chk("b.rom_addr", 32'(if_b.rom_addr), 32'(baddr));
    chk("b.rvalid0", 32'(if_b.rvalid0), 32'(exp_rv[1][0]));
    chk("b.rvalid1", 32'(if_b.rvalid1), 32'(exp_rv[1][1]));
    chk("b.rdata0", 32'(if_b.rdata0), 32'(exp_rd[1][0]));
    chk("b.rdata1", 32'(if_b.rdata1), 32'(exp_rd[1][1]));

    if (r) begin
      if (beat) begin
        for (int d = 0; d < 2; d++) begin
          lat = (d == 0) ? LAT_A : LAT_B;
          s   = (cyc + lat + 1) % 8;
          sch_vld[d][s] = 1;
          sch_id[d][s]  = owner - 1;
          sch_dat[d][s] = baddr & 63;
        end
      end
      model_next(r0, r1, beat);
    end
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    if_a.req0 = 1'b0;  if_a.req1 = 1'b0;  if_a.addr0 = '0;  if_a.addr1 = '0;
    if_b.req0 = 1'b0;  if_b.req1 = 1'b0;  if_b.addr0 = '0;  if_b.addr1 = '0;
    model_reset();

    phase = "reset";
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 5, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 7 + i, 0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);

    phase = "single";
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, i, 0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);

    phase = "contend";
    for (int i = 0; i < 80; i++) cycle(1'b1, 1'b1, 1'b1, 100 + i, 2000 + i);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);

    phase = "drop";
    cycle(1'b1, 1'b0, 1'b1, 0, 300);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 400 + i, 301 + i);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 410 + i, 0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);

    phase = "prio";
    cycle(1'b1, 1'b0, 1'b1, 0, 500);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 0, 501 + i);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b1, 700 + i, 511 + i);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 800 + i, 900 + i);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);

    phase = "rst_mid";
    cycle(1'b1, 1'b1, 1'b0, 33, 0);
    cycle(1'b1, 1'b1, 1'b0, 34, 0);
    cycle(1'b0, 1'b1, 1'b0, 35, 0);
    cycle(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);

    phase = "random";
    q0 = 1'b0;
    q1 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) q0 = !q0;
      if ($urandom_range(7) == 0) q1 = !q1;
      rr = ($urandom_range(249) != 0);
      cycle(rr, q0, q1, int'($urandom_range(8191)), int'($urandom_range(8191)));
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
